cpld_spi_responder: RTL

CPLD_SPI_RESPONDER -- requirements
Module: cpld_spi_responder

---
 rtl/cpld_spi_pkg.sv | 12 +
 rtl/cpld_sync_edge.sv | 22 ++
 rtl/cpld_spi_responder.sv | 93 +++++++++
 3 files changed

// File: rtl/cpld_spi_pkg.sv
// cpld_spi_pkg: frame layout, register map and FSM encoding shared by the SPI responder
package cpld_spi_pkg;
  localparam int FRAME_LEN = 16;
  localparam int CMD_LEN = 8;
  localparam int RNW_BIT = 15;
  localparam int SYNC_LATENCY = 3;
  localparam logic [6:0] ADDR_ID = 7'h00;
  localparam logic [6:0] ADDR_STATUS = 7'h01;
  localparam logic [6:0] ADDR_CTRL = 7'h02;
  localparam logic [6:0] ADDR_SCRATCH = 7'h03;
  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2, OVER = 2'd3} state_t;
endpackage

// File: rtl/cpld_sync_edge.sv
// cpld_sync_edge: two-flop synchronizer plus one history flop for edge detection
module cpld_sync_edge
  import cpld_spi_pkg::*;
#(
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [SYNC_LATENCY-1:0] sr;
  // shift the asynchronous input through the synchronizer and history stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= {SYNC_LATENCY{IDLE_VAL}};
    else sr <= {sr[SYNC_LATENCY-2:0], d};
  assign q = sr[SYNC_LATENCY-2];
  assign rise = sr[SYNC_LATENCY-2] & ~sr[SYNC_LATENCY-1];
  assign fall = ~sr[SYNC_LATENCY-2] & sr[SYNC_LATENCY-1];
endmodule

// File: rtl/cpld_spi_responder.sv
// cpld_spi_responder: SPI mode 0 register responder clocked from the CPLD oscillator
module cpld_spi_responder
  import cpld_spi_pkg::*;
#(
  parameter logic [7:0] ID_VALUE = 8'hA5,
  parameter int MIN_HALF_PERIOD = 4
) (
  input  logic       sysclk,
  input  logic       reset_INV,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs_INV,
  output logic       spi_miso,
  input  logic [7:0] status_in,
  output logic [7:0] ctrl_out,
  output logic       wr_strobe,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);
  // miso must settle SYNC_LATENCY cycles after a falling edge, before the next rising edge
  if (MIN_HALF_PERIOD < SYNC_LATENCY + 1) begin : g_half_period_check
    $error("MIN_HALF_PERIOD too short for the synchronizer latency");
  end
  logic cs_q, cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_q;
  logic unused_sclk_q;
  logic [1:0] unused_mosi_edges;
  state_t state, state_d;
  logic [4:0] cnt;
  logic [15:0] shreg, sh_next;
  logic [7:0] rd_word, rd_sel, scratch;
  logic [6:0] rd_addr;
  logic shift, commit, start, last_cmd_bit;
  cpld_sync_edge #(.IDLE_VAL(1'b1)) u_cs (.clk(sysclk), .rst_n(reset_INV), .d(spi_cs_INV), .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  cpld_sync_edge #(.IDLE_VAL(1'b0)) u_sclk (.clk(sysclk), .rst_n(reset_INV), .d(spi_clk), .q(unused_sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  cpld_sync_edge #(.IDLE_VAL(1'b0)) u_mosi (.clk(sysclk), .rst_n(reset_INV), .d(spi_mosi), .q(mosi_q), .rise(unused_mosi_edges[1]), .fall(unused_mosi_edges[0]));
  assign busy = ~cs_q;
  assign sh_next = {shreg[14:0], mosi_q};
  assign rd_addr = sh_next[6:0];
  assign start = state == IDLE && cs_fall;
  assign shift = sclk_rise && !cs_rise && (state == CMD || state == DATA);
  assign last_cmd_bit = shift && state == CMD && cnt == 5'(CMD_LEN - 1);
  assign commit = cs_rise && cnt >= 5'(FRAME_LEN) && !shreg[RNW_BIT];
  assign rd_sel = rd_addr == ADDR_ID      ? ID_VALUE :
                  rd_addr == ADDR_STATUS  ? status_in :
                  rd_addr == ADDR_CTRL    ? ctrl_out :
                  rd_addr == ADDR_SCRATCH ? scratch : 8'h00;
  // frame state register
  always_ff @(posedge sysclk or negedge reset_INV)
    if (!reset_INV) state <= IDLE;
    else state <= state_d;
  // next state: a chip-select release wins over any simultaneous clock edge
  always_comb begin
    state_d = cs_rise ? IDLE :
              start ? CMD :
              last_cmd_bit ? DATA :
              (shift && state == DATA && cnt == 5'(FRAME_LEN - 1)) ? OVER : state;
  end
  // bit capture, read-word serialisation and write commit
  always_ff @(posedge sysclk or negedge reset_INV)
    if (!reset_INV) begin
      cnt <= '0;
      shreg <= '0;
      rd_word <= '0;
      spi_miso <= 1'b0;
      ctrl_out <= '0;
      scratch <= '0;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_strobe <= commit;
      if (commit) begin
        wr_addr <= shreg[14:8];
        wr_data <= shreg[7:0];
        if (shreg[14:8] == ADDR_CTRL) ctrl_out <= shreg[7:0];
        if (shreg[14:8] == ADDR_SCRATCH) scratch <= shreg[7:0];
      end
      if (start) begin
        cnt <= '0;
        shreg <= '0;
      end else if (shift) begin
        cnt <= cnt + 5'd1;
        shreg <= sh_next;
      end
      if (last_cmd_bit) rd_word <= rd_sel;
      if (state != DATA || cs_rise) spi_miso <= 1'b0;
      else if (sclk_fall) begin
        spi_miso <= rd_word[7];
        rd_word <= {rd_word[6:0], 1'b0};
      end
    end
endmodule
